// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg
//   Shared front-end control definitions: decode-stage PC-select encodings,
//   fetch FSM state encodings, the default reset PC and the base opcodes
//   whose decode produces the PC-select field.
package pc_gen_pkg;

  // Default first fetch address after reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_2000;

  // Decode-stage next-PC select. 2'b10 is reserved and behaves as PC4.
  typedef enum logic [1:0] {
    PC4     = 2'b00,
    PC_IMM  = 2'b01,
    PC_RSV  = 2'b10,
    RS1_IMM = 2'b11
  } pc_sel_e;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } pc_state_e;

  // Base opcodes that drive the PC-select field.
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;  // selects PC_IMM
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;  // selects RS1_IMM
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;  // resolved in execute (redirect)

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if
//   Groups the fetch/decode control signals of the PC generator.
//   master : upstream pipeline (drives select, operands, redirect, stall)
//   slave  : pc_gen (drives icache request, decode PC/valid, error flag)
interface pc_gen_if;
  import pc_gen_pkg::*;

  pc_sel_e     pc_add_sel;       // decode-stage next-PC select
  logic [31:0] imm;              // sign-extended immediate (decode)
  logic [31:0] rs1_data;         // forwarded rs1 (decode)
  logic        redirect_valid;   // execute-stage taken branch
  logic [31:0] redirect_target;  // branch target
  logic        stall;            // hold all state
  logic [31:0] icache_addr;      // fetch address
  logic        icache_re;        // fetch request
  logic [31:0] dec_pc;           // PC of the decode-stage instruction
  logic        dec_valid;        // decode-stage instruction is live
  logic        misalign_err;     // sticky misaligned-target flag

  modport master (
    output pc_add_sel, imm, rs1_data, redirect_valid, redirect_target, stall,
    input  icache_addr, icache_re, dec_pc, dec_valid, misalign_err
  );

  modport slave (
    input  pc_add_sel, imm, rs1_data, redirect_valid, redirect_target, stall,
    output icache_addr, icache_re, dec_pc, dec_valid, misalign_err
  );

endinterface

// File: rtl/pc_target_mux.sv
// pc_target_mux
//   Combinational next-PC selection and misalignment check.
//   Ports:
//     fetch_pc, dec_pc, dec_valid : current fetch/decode state
//     sel, imm, rs1_data          : decode-stage jump request
//     redirect_valid/target       : execute-stage branch redirect
//     next_pc                     : selected next fetch address
//     squash                      : a control transfer was taken
//     misalign                    : next_pc is not word aligned
module pc_target_mux
  import pc_gen_pkg::*;
(
  input  logic [31:0] fetch_pc,
  input  logic [31:0] dec_pc,
  input  logic        dec_valid,
  input  pc_sel_e     sel,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] next_pc,
  output logic        squash,
  output logic        misalign
);

  logic [31:0] rs1_imm_sum;

  assign rs1_imm_sum = rs1_data + imm;

  // Redirect from execute beats any decode-stage jump, since the decode
  // instruction itself is on the wrong path when execute redirects.
  always_comb begin
    next_pc = fetch_pc + 32'd4;
    squash  = 1'b0;
    if (redirect_valid) begin
      next_pc = redirect_target;
      squash  = 1'b1;
    end else if (dec_valid) begin
      case (sel)
        PC_IMM: begin
          next_pc = dec_pc + imm;
          squash  = 1'b1;
        end
        RS1_IMM: begin
          next_pc = {rs1_imm_sum[31:1], 1'b0};
          squash  = 1'b1;
        end
        default: begin
          next_pc = fetch_pc + 32'd4;
          squash  = 1'b0;
        end
      endcase
    end
  end

  assign misalign = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/pc_gen.sv
// pc_gen
//   Fetch PC generator: BOOT/RUN/HALT FSM plus fetch and decode PC registers.
//   Ports:
//     clk   : sole clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : pc_gen_if.slave (select/operands/redirect/stall in;
//             icache_addr/icache_re/dec_pc/dec_valid/misalign_err out)
//   Parameter RESET_PC is the first fetch address after reset.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_gen_if.slave  bus
);

  pc_state_e   state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic [31:0] dec_pc_reg, dec_pc_next;
  logic        dec_valid_reg, dec_valid_next;
  logic        misalign_reg, misalign_next;

  logic [31:0] target_pc;
  logic        target_squash;
  logic        target_misalign;

  pc_target_mux u_target_mux (
    .fetch_pc        (fetch_pc_reg),
    .dec_pc          (dec_pc_reg),
    .dec_valid       (dec_valid_reg),
    .sel             (bus.pc_add_sel),
    .imm             (bus.imm),
    .rs1_data        (bus.rs1_data),
    .redirect_valid  (bus.redirect_valid),
    .redirect_target (bus.redirect_target),
    .next_pc         (target_pc),
    .squash          (target_squash),
    .misalign        (target_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= BOOT;
      fetch_pc_reg  <= RESET_PC;
      dec_pc_reg    <= 32'd0;
      dec_valid_reg <= 1'b0;
      misalign_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      fetch_pc_reg  <= fetch_pc_next;
      dec_pc_reg    <= dec_pc_next;
      dec_valid_reg <= dec_valid_next;
      misalign_reg  <= misalign_next;
    end
  end

  // BOOT and RUN share the datapath: BOOT is simply the cycle in which the
  // reset PC is on the bus and nothing is in decode yet (dec_valid=0, so
  // decode-stage jumps are ignored automatically).
  always_comb begin
    state_next     = state_reg;
    fetch_pc_next  = fetch_pc_reg;
    dec_pc_next    = dec_pc_reg;
    dec_valid_next = dec_valid_reg;
    misalign_next  = misalign_reg;
    case (state_reg)
      BOOT, RUN: begin
        if (!bus.stall) begin
          if (target_misalign) begin
            // Misaligned target is never fetched; freeze fetch PC.
            state_next     = HALT;
            misalign_next  = 1'b1;
            dec_valid_next = 1'b0;
          end else begin
            state_next     = RUN;
            fetch_pc_next  = target_pc;
            dec_pc_next    = fetch_pc_reg;
            // The instruction fetched this cycle is on the wrong path
            // whenever a control transfer was taken.
            dec_valid_next = !target_squash;
          end
        end
      end
      HALT: begin
        dec_valid_next = 1'b0;
      end
      default: begin
        state_next     = HALT;
        misalign_next  = 1'b1;
        dec_valid_next = 1'b0;
      end
    endcase
  end

  assign bus.icache_addr  = fetch_pc_reg;
  // Gated by rst_n so the request drops immediately while reset is held.
  assign bus.icache_re    = rst_n && (state_reg != HALT);
  assign bus.dec_pc       = dec_pc_reg;
  assign bus.dec_valid    = dec_valid_reg;
  assign bus.misalign_err = misalign_reg;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;
  import pc_gen_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pc_gen_if bus ();

  pc_gen #(.RESET_PC(32'h0000_2000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] addr, input logic re,
                           input logic [31:0] dpc, input logic dv, input logic mis);
    chk({tag, ".addr"}, bus.icache_addr, addr);
    chk({tag, ".re"}, {31'd0, bus.icache_re}, {31'd0, re});
    chk({tag, ".dec_pc"}, bus.dec_pc, dpc);
    chk({tag, ".dec_valid"}, {31'd0, bus.dec_valid}, {31'd0, dv});
    chk({tag, ".misalign"}, {31'd0, bus.misalign_err}, {31'd0, mis});
    $display("t=%0t %s addr=%h re=%b dec_pc=%h dv=%b mis=%b", $time, tag,
             bus.icache_addr, bus.icache_re, bus.dec_pc, bus.dec_valid, bus.misalign_err);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.pc_add_sel      = PC4;
    bus.imm             = 32'd0;
    bus.rs1_data        = 32'd0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'd0;
    bus.stall           = 1'b0;

    // Reset state
    step(); step();
    chk_state("reset", 32'h2000, 1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk_state("boot", 32'h2000, 1'b1, 32'h0, 1'b0, 1'b0);

    // Straight-line run
    step(); chk_state("run1", 32'h2004, 1'b1, 32'h2000, 1'b1, 1'b0);
    step(); chk_state("run2", 32'h2008, 1'b1, 32'h2004, 1'b1, 1'b0);

    // pc+imm jump from dec_pc=2004
    bus.pc_add_sel = PC_IMM; bus.imm = 32'h100;
    step(); chk_state("jal", 32'h2104, 1'b1, 32'h2008, 1'b0, 1'b0);
    // sel still 01 but decode squashed: behaves as pc+4
    step(); chk_state("jal_land", 32'h2108, 1'b1, 32'h2104, 1'b1, 1'b0);
    // reserved select behaves as pc+4
    bus.pc_add_sel = PC_RSV;
    step(); chk_state("rsv", 32'h210C, 1'b1, 32'h2108, 1'b1, 1'b0);

    // rs1+imm with bit0 cleared
    bus.pc_add_sel = RS1_IMM; bus.rs1_data = 32'h3001; bus.imm = 32'h4;
    step(); chk_state("jalr", 32'h3004, 1'b1, 32'h210C, 1'b0, 1'b0);
    bus.pc_add_sel = PC4;
    step(); chk_state("jalr_land", 32'h3008, 1'b1, 32'h3004, 1'b1, 1'b0);

    // simultaneous jalr and redirect: redirect wins
    bus.pc_add_sel = RS1_IMM; bus.redirect_valid = 1'b1; bus.redirect_target = 32'h4000;
    step(); chk_state("redir_win", 32'h4000, 1'b1, 32'h3008, 1'b0, 1'b0);
    bus.pc_add_sel = PC4; bus.redirect_valid = 1'b0;
    step(); chk_state("redir_land", 32'h4004, 1'b1, 32'h4000, 1'b1, 1'b0);

    // stall with pending redirect and jump: everything frozen
    bus.stall = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_target = 32'h5000;
    bus.pc_add_sel = PC_IMM; bus.imm = 32'h8;
    for (int i = 0; i < 3; i++) begin
      step(); chk_state("stall", 32'h4004, 1'b1, 32'h4000, 1'b1, 1'b0);
    end
    bus.stall = 1'b0;
    step(); chk_state("unstall", 32'h5000, 1'b1, 32'h4004, 1'b0, 1'b0);
    bus.redirect_valid = 1'b0; bus.pc_add_sel = PC4;
    step(); chk_state("unstall_land", 32'h5004, 1'b1, 32'h5000, 1'b1, 1'b0);

    // 32-bit wrap of pc+4
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'hFFFF_FFFC;
    step(); chk_state("wrap_redir", 32'hFFFF_FFFC, 1'b1, 32'h5004, 1'b0, 1'b0);
    bus.redirect_valid = 1'b0;
    step(); chk_state("wrap0", 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
    step(); chk_state("wrap4", 32'h4, 1'b1, 32'h0, 1'b1, 1'b0);

    // misaligned pc+imm target 0+2102 -> HALT
    bus.pc_add_sel = PC_IMM; bus.imm = 32'h2102;
    step(); chk_state("misalign", 32'h4, 1'b0, 32'h0, 1'b0, 1'b1);
    bus.pc_add_sel = PC4; bus.redirect_valid = 1'b1; bus.redirect_target = 32'h6000;
    step(); chk_state("halt_hold", 32'h4, 1'b0, 32'h0, 1'b0, 1'b1);
    bus.redirect_valid = 1'b0;

    // asynchronous reset out of HALT
    rst_n = 1'b0;
    #1;
    chk_state("halt_reset", 32'h2000, 1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    #1;
    chk_state("reboot", 32'h2000, 1'b1, 32'h0, 1'b0, 1'b0);
    step(); chk_state("reboot_run", 32'h2004, 1'b1, 32'h2000, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL take parameter RESET_PC, default 32'h0000_2000, first fetch address after reset.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port pc_add_sel  in  2  decode-stage select: 00 pc+4, 01 pc+imm, 11 rs1+imm, 10 reserved.
REQ-005 SHALL have port imm  in  32  sign-extended immediate of the decode-stage instruction.
REQ-006 SHALL have port rs1_data  in  32  forwarded rs1 of the decode-stage instruction.
REQ-007 SHALL have port redirect_valid  in  1  execute-stage taken branch.
REQ-008 SHALL have port redirect_target  in  32  branch target.
REQ-009 SHALL have port stall  in  1  hold all state (icache miss or hazard).
REQ-010 SHALL have port icache_addr  out  32  fetch address.
REQ-011 SHALL have port icache_re  out  1  fetch request.
REQ-012 SHALL have port dec_pc  out  32  PC of the instruction currently in decode.
REQ-013 SHALL have port dec_valid  out  1  decode-stage instruction is live, not squashed.
REQ-014 SHALL have port misalign_err  out  1  sticky misaligned-target flag.

Function
REQ-015 SHALL implement states BOOT, RUN, HALT.
REQ-016 BOOT: one cycle after reset release; icache_addr=RESET_PC, icache_re=1, dec_valid=0; then RUN.
REQ-017 RUN, stall=0: fetch_pc advances each cycle; dec_pc <= fetch_pc; dec_valid <= 1 unless a squash is pending.
REQ-018 Next fetch_pc SHALL follow this priority: redirect_valid -> redirect_target; else if dec_valid and sel=01 -> dec_pc+imm; else if dec_valid and sel=11 -> (rs1_data+imm) with bit0 cleared; else fetch_pc+4.
REQ-019 sel=10 or dec_valid=0 SHALL be treated as 00.
REQ-020 All adds SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-021 A taken jump (sel 01/11 with dec_valid) SHALL squash the one wrong-path fetch: dec_valid=0 next cycle.
REQ-022 A redirect SHALL squash the wrong-path fetch identically and override a simultaneous jump.
REQ-023 stall=1 SHALL hold fetch_pc, dec_pc, dec_valid and state; icache_re stays 1 with unchanged icache_addr.
REQ-024 A redirect or jump during stall SHALL be ignored; upstream holds redirect_valid until stall drops.
REQ-025 A selected next PC with bits[1:0]!=0 SHALL NOT be fetched; instead the block enters HALT, sets misalign_err=1, and drops icache_re and dec_valid.
REQ-026 HALT SHALL be left only by reset; misalign_err holds 1 until then.
REQ-027 icache_addr SHALL be the registered fetch_pc, with no combinational path from inputs.

Reset
REQ-028 Asserting rst_n low SHALL asynchronously force state=BOOT, fetch_pc=RESET_PC, dec_pc=0, dec_valid=0, misalign_err=0, icache_re=0.
REQ-029 Reset mid-stall or mid-squash SHALL discard all pending state; no squash survives reset.

Structure
REQ-030 PC-select encodings (PC4, PC_IMM, RS1_IMM), state encodings and the RESET_PC default SHALL live in the shared control package/header beside the opcode definitions.
REQ-031 One sub-module, pc_target_mux, SHALL compute the combinational next PC and misalign check; pc_gen holds the FSM and registers.

Verification
REQ-032 Reset, then straight-line run with sel=00 for 3 cycles -> icache_addr 2000, 2004, 2008, 200C; dec_valid=0 in BOOT, then 1.
REQ-033 dec_pc=2004, sel=01, imm=32'h100 -> next icache_addr=2104; next-cycle dec_valid=0; the following cycle dec_valid=1 with dec_pc=2104.
REQ-034 sel=11, rs1=32'h3001, imm=4 -> icache_addr=3004 (bit0 cleared); a simultaneous redirect to 4000 wins, giving icache_addr=4000.
REQ-035 stall=1 for 3 cycles during a redirect -> icache_addr, dec_pc and dec_valid frozen; redirect taken on the first unstalled cycle.
REQ-036 sel=01 with target 2102 -> HALT, misalign_err=1, icache_re=0; rst_n pulse low -> BOOT at 2000 with misalign_err=0.
